// File: rtl/vga_pkg.sv
// Shared raster constants, the 24-bit colour type and a window helper for
// the VGA output path.
package vga_pkg;

  localparam int COORD_W = 11;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb24_t;

  // True when val lies in [lo, lo+len-1].
  function automatic logic in_window(input logic [COORD_W-1:0] val,
                                     input int lo, input int len);
    return (int'(val) >= lo) && (int'(val) < lo + len);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with a per-bit reset value; depth 0 is a wire.
module sync_delay_line #(
  parameter int              DEPTH     = 2,
  parameter int              WIDTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, reset};
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_out.sv
// Free-running raster generator plus the registered, blanked output stage that
// lines sync/blank up with colour arriving PIPE_DELAY clocks after coordinates.
module vga_timing_out
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE   = DEF_H_ACTIVE,
  parameter int   H_FP       = DEF_H_FP,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BP       = DEF_H_BP,
  parameter int   V_ACTIVE   = DEF_V_ACTIVE,
  parameter int   V_FP       = DEF_V_FP,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BP       = DEF_V_BP,
  parameter int   PIPE_DELAY = 2,
  parameter logic SYNC_POL   = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         redIn,
  input  logic [7:0]         greenIn,
  input  logic [7:0]         blueIn,
  output logic [COORD_W-1:0] pixelX,
  output logic [COORD_W-1:0] pixelY,
  output logic               pixelValid,
  output logic               startOfFrame,
  output logic               hSync,
  output logic               vSync,
  output logic               blankN,
  output logic [7:0]         redOut,
  output logic [7:0]         greenOut,
  output logic [7:0]         blueOut
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS  = COORD_W'(V_ACTIVE);

  logic [COORD_W-1:0] h_cnt, v_cnt, h_next, v_next;
  logic               h_wrap;

  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    h_next = h_wrap ? '0 : h_cnt + COORD_W'(1);
    v_next = v_cnt;
    if (h_wrap) v_next = (v_cnt == V_LAST) ? '0 : v_cnt + COORD_W'(1);
  end

  // Coordinate outputs register the next count so (0,0) appears on the very
  // first clock after reset release.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt        <= H_LAST;
      v_cnt        <= V_LAST;
      pixelX       <= '0;
      pixelY       <= '0;
      pixelValid   <= 1'b0;
      startOfFrame <= 1'b0;
    end else begin
      h_cnt        <= h_next;
      v_cnt        <= v_next;
      pixelX       <= h_next;
      pixelY       <= v_next;
      pixelValid   <= (h_next < H_VIS) && (v_next < V_VIS);
      startOfFrame <= (h_next == '0) && (v_next == '0);
    end
  end

  logic       hs_raw, vs_raw;
  logic [2:0] raw_bus, dly_bus;

  assign hs_raw  = in_window(pixelX, H_ACTIVE + H_FP, H_SYNC);
  assign vs_raw  = in_window(pixelY, V_ACTIVE + V_FP, V_SYNC);
  assign raw_bus = {hs_raw, vs_raw, pixelValid};

  sync_delay_line #(
    .DEPTH     (PIPE_DELAY),
    .WIDTH     (3),
    .RESET_VAL (3'b000)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .din   (raw_bus),
    .dout  (dly_bus)
  );

  rgb24_t colour_in, colour_out;

  assign colour_in = '{red: redIn, green: greenIn, blue: blueIn};

  // Final stage: colour sampled now belongs to the delayed valid bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      hSync      <= ~SYNC_POL;
      vSync      <= ~SYNC_POL;
      blankN     <= 1'b0;
      colour_out <= '0;
    end else begin
      hSync      <= dly_bus[2] ? SYNC_POL : ~SYNC_POL;
      vSync      <= dly_bus[1] ? SYNC_POL : ~SYNC_POL;
      blankN     <= dly_bus[0];
      colour_out <= dly_bus[0] ? colour_in : '0;
    end
  end

  assign redOut   = colour_out.red;
  assign greenOut = colour_out.green;
  assign blueOut  = colour_out.blue;

endmodule

// File: tb/tb_vga_timing_out.sv
// Directed bench for vga_timing_out: default 640x480 timing with a per-clock
// pipeline model, plus a tiny raster built with PIPE_DELAY = 0, SYNC_POL = 1.
module tb_vga_timing_out;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reset_small = 1'b1;
  logic [7:0]  redIn = 8'hFF, greenIn = 8'hFF, blueIn = 8'hFF;
  logic [10:0] pixelX, pixelY;
  logic        pixelValid, startOfFrame, hSync, vSync, blankN;
  logic [7:0]  redOut, greenOut, blueOut;

  logic [7:0]  red_s = 8'hC3, green_s = 8'h3C, blue_s = 8'hFF;
  logic [10:0] pixelX_s, pixelY_s;
  logic        pixelValid_s, startOfFrame_s, hSync_s, vSync_s, blankN_s;
  logic [7:0]  redOut_s, greenOut_s, blueOut_s;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  always #20 clk = ~clk;

  vga_timing_out dut (
    .clk(clk), .reset(reset),
    .redIn(redIn), .greenIn(greenIn), .blueIn(blueIn),
    .pixelX(pixelX), .pixelY(pixelY), .pixelValid(pixelValid),
    .startOfFrame(startOfFrame), .hSync(hSync), .vSync(vSync), .blankN(blankN),
    .redOut(redOut), .greenOut(greenOut), .blueOut(blueOut)
  );

  // 16 x 8 raster: hsync window x 10..12, vsync window y 5..6.
  vga_timing_out #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIPE_DELAY(0), .SYNC_POL(1'b1)
  ) dut_small (
    .clk(clk), .reset(reset_small),
    .redIn(red_s), .greenIn(green_s), .blueIn(blue_s),
    .pixelX(pixelX_s), .pixelY(pixelY_s), .pixelValid(pixelValid_s),
    .startOfFrame(startOfFrame_s), .hSync(hSync_s), .vSync(vSync_s), .blankN(blankN_s),
    .redOut(redOut_s), .greenOut(greenOut_s), .blueOut(blueOut_s)
  );

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        vis;
    logic        hs;
    logic        vs;
    logic        sof;
  } pix_t;

  // hist[0] = pixel now on pixelX/pixelY, hist[3] = pixel now on the outputs.
  pix_t hist [4];
  int   mcx = 799;
  int   mcy = 524;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_model();
    check_output("m_x",     32'(pixelX),       32'(hist[0].x));
    check_output("m_y",     32'(pixelY),       32'(hist[0].y));
    check_output("m_valid", 32'(pixelValid),   32'(hist[0].vis));
    check_output("m_sof",   32'(startOfFrame), 32'(hist[0].sof));
    check_output("m_hsync", 32'(hSync),        32'(!hist[3].hs));
    check_output("m_vsync", 32'(vSync),        32'(!hist[3].vs));
    check_output("m_blank", 32'(blankN),       32'(hist[3].vis));
    check_output("m_red",   32'(redOut),   hist[3].vis ? 32'(hist[3].x[7:0]) : 32'h0);
    check_output("m_green", 32'(greenOut), hist[3].vis ? 32'(hist[3].y[7:0]) : 32'h0);
    check_output("m_blue",  32'(blueOut),  hist[3].vis ? 32'(hist[3].x[7:0] ^ 8'h3C) : 32'h0);
  endtask

  // One clock: update the raster model, drive colour for the pixel two
  // clocks back (or 0xFF when that pixel is blanked), then check everything.
  task automatic tick();
    logic rst;
    rst = reset;
    @(posedge clk);
    #1;
    cycle++;
    if (rst) begin
      mcx = 799;
      mcy = 524;
      for (int i = 0; i < 4; i++) hist[i] = '0;
    end else begin
      if (mcx == 799) begin
        mcx = 0;
        mcy = (mcy == 524) ? 0 : mcy + 1;
      end else begin
        mcx++;
      end
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0].x   = 11'(mcx);
      hist[0].y   = 11'(mcy);
      hist[0].vis = (mcx < 640) && (mcy < 480);
      hist[0].hs  = (mcx >= 656) && (mcx <= 751);
      hist[0].vs  = (mcy >= 490) && (mcy <= 491);
      hist[0].sof = (mcx == 0) && (mcy == 0);
    end
    if (hist[2].vis) begin
      redIn   = hist[2].x[7:0];
      greenIn = hist[2].y[7:0];
      blueIn  = hist[2].x[7:0] ^ 8'h3C;
    end else begin
      redIn   = 8'hFF;
      greenIn = 8'hFF;
      blueIn  = 8'hFF;
    end
    check_model();
  endtask

  initial begin
    int   first_cycle, t656, fall1, rise1, fall2, blank_hi, hs_low, s0, idx;
    int   first_hs_s, first_vs_s, vs_cnt_s, sof_cnt_s, sof2_s, blank_fall_s;
    logic prev_hs, prev_bn, found;

    for (int i = 0; i < 4; i++) hist[i] = '0;

    $display("[TB] reset and release");
    reset = 1'b1;
    repeat (3) tick();
    check_output("rst_hsync", 32'(hSync), 32'h1);
    check_output("rst_vsync", 32'(vSync), 32'h1);
    check_output("rst_blank", 32'(blankN), 32'h0);
    check_output("rst_red",   32'(redOut), 32'h0);
    check_output("rst_valid", 32'(pixelValid), 32'h0);
    check_output("rst_s_hsync", 32'(hSync_s), 32'h0);
    check_output("rst_s_vsync", 32'(vSync_s), 32'h0);
    check_output("rst_s_blank", 32'(blankN_s), 32'h0);

    reset = 1'b0;
    tick();
    first_cycle = cycle;
    check_output("first_x",     32'(pixelX), 32'h0);
    check_output("first_y",     32'(pixelY), 32'h0);
    check_output("first_sof",   32'(startOfFrame), 32'h1);
    check_output("first_valid", 32'(pixelValid), 32'h1);

    $display("[TB] line timing");
    t656 = -1; fall1 = -1; rise1 = -1; fall2 = -1; blank_hi = 0;
    prev_hs = hSync;
    for (int i = 0; i < 1700; i++) begin
      tick();
      if (pixelX == 11'd656 && pixelY == 11'd0 && t656 < 0) t656 = cycle;
      if (prev_hs && !hSync) begin
        if (fall1 < 0) fall1 = cycle;
        else if (fall2 < 0) fall2 = cycle;
      end
      if (!prev_hs && hSync && fall1 >= 0 && rise1 < 0) rise1 = cycle;
      if (cycle - first_cycle >= 3 && cycle - first_cycle < 803 && blankN) blank_hi++;
      prev_hs = hSync;
    end
    check_output("hsync_latency", 32'(fall1 - t656), 32'd3);
    check_output("hsync_width",   32'(rise1 - fall1), 32'd96);
    check_output("hsync_period",  32'(fall2 - fall1), 32'd800);
    check_output("blank_per_line", 32'(blank_hi), 32'd640);

    $display("[TB] mid-frame reset at (300,2)");
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      if (pixelX == 11'd300 && pixelY == 11'd2) found = 1'b1;
    end
    check_output("reach_300_2", 32'(found), 32'h1);
    reset = 1'b1;
    tick();
    check_output("mid_rst_x",     32'(pixelX), 32'h0);
    check_output("mid_rst_y",     32'(pixelY), 32'h0);
    check_output("mid_rst_valid", 32'(pixelValid), 32'h0);
    check_output("mid_rst_sof",   32'(startOfFrame), 32'h0);
    check_output("mid_rst_hsync", 32'(hSync), 32'h1);
    check_output("mid_rst_blank", 32'(blankN), 32'h0);
    check_output("mid_rst_green", 32'(greenOut), 32'h0);
    reset = 1'b0;
    tick();
    check_output("restart_x",   32'(pixelX), 32'h0);
    check_output("restart_y",   32'(pixelY), 32'h0);
    check_output("restart_sof", 32'(startOfFrame), 32'h1);
    hs_low = 0;
    for (int i = 0; i < 640; i++) begin
      tick();
      if (!hSync) hs_low++;
    end
    check_output("no_residual_hsync", 32'(hs_low), 32'h0);

    $display("[TB] reset while hsync asserted");
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (pixelX == 11'd720) found = 1'b1;
    end
    check_output("reach_720", 32'(found), 32'h1);
    check_output("hsync_active_720", 32'(hSync), 32'h0);
    reset = 1'b1;
    tick();
    check_output("hsync_cut_by_reset", 32'(hSync), 32'h1);
    reset = 1'b0;
    tick();
    check_output("restart2_sof", 32'(startOfFrame), 32'h1);

    $display("[TB] small raster, zero pipeline delay, active-high sync");
    reset_small = 1'b0;
    tick();
    s0 = cycle;
    check_output("s_first_x",     32'(pixelX_s), 32'h0);
    check_output("s_first_sof",   32'(startOfFrame_s), 32'h1);
    check_output("s_first_valid", 32'(pixelValid_s), 32'h1);
    check_output("s_first_blank", 32'(blankN_s), 32'h0);
    tick();
    check_output("s_blank_rise", 32'(blankN_s), 32'h1);
    check_output("s_red_vis",    32'(redOut_s), 32'hC3);
    check_output("s_blue_vis",   32'(blueOut_s), 32'hFF);
    first_hs_s = -1; first_vs_s = -1; vs_cnt_s = 0; sof_cnt_s = 0; sof2_s = -1;
    blank_fall_s = -1;
    prev_bn = blankN_s;
    for (int i = 0; i < 300; i++) begin
      tick();
      idx = cycle - s0;
      if (hSync_s && first_hs_s < 0) first_hs_s = idx;
      if (vSync_s && first_vs_s < 0) first_vs_s = idx;
      if (vSync_s && idx < 128) vs_cnt_s++;
      if (startOfFrame_s && idx <= 256) begin
        sof_cnt_s++;
        if (sof2_s < 0) sof2_s = idx;
      end
      if (prev_bn && !blankN_s && blank_fall_s < 0) blank_fall_s = idx;
      if (idx == 9) begin
        check_output("s_red_blanked",   32'(redOut_s), 32'h0);
        check_output("s_blue_blanked",  32'(blueOut_s), 32'h0);
      end
      prev_bn = blankN_s;
    end
    check_output("s_hsync_latency", 32'(first_hs_s), 32'd11);
    check_output("s_blank_fall",    32'(blank_fall_s), 32'd9);
    check_output("s_vsync_start",   32'(first_vs_s), 32'd81);
    check_output("s_vsync_width",   32'(vs_cnt_s), 32'd32);
    check_output("s_sof_count",     32'(sof_cnt_s), 32'd2);
    check_output("s_sof_period",    32'(sof2_s), 32'd128);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
